// File: rtl/alsu_ctrl_pkg.sv
// alsu_ctrl_pkg: command layout, opcodes, arbiter states and legality check for alsu_cmd_arbiter
package alsu_ctrl_pkg;
  localparam logic [2:0] OR = 3'd0, XOR = 3'd1, ADD = 3'd2, MULT = 3'd3, SHIFT = 3'd4, ROTATE = 3'd5;
  typedef struct packed {
    logic [2:0] opcode;
    logic signed [2:0] A;
    logic signed [2:0] B;
    logic cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B;
  } alsu_cmd_t;
  localparam int CMD_W = $bits(alsu_cmd_t);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;
  function automatic logic cmd_illegal(alsu_cmd_t c);
    return (c.opcode inside {3'd6, 3'd7}) || ((c.red_op_A || c.red_op_B) && !(c.opcode inside {OR, XOR}));
  endfunction
endpackage

// File: rtl/alsu_rr_arbiter.sv
// alsu_rr_arbiter: combinational round-robin grant, first asserted req_i at or above ptr_i with wrap
// req_i: request vector, ptr_i: search start, gnt_o: one-hot grant, gnt_id_o: granted index, any_o: grant present
module alsu_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_id_o,
  output logic               any_o
);
  logic [ID_W-1:0] idx;
  // Scanning from the farthest offset down lets the nearest hit overwrite earlier ones.
  always_comb begin
    gnt_id_o = '0;
    any_o = 1'b0;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ID_W'((int'(ptr_i) + i) % NUM_REQ);
      if (req_i[idx]) begin
        gnt_id_o = idx;
        any_o = 1'b1;
      end
    end
    gnt_o = any_o ? NUM_REQ'(1) << gnt_id_o : '0;
  end
endmodule

// File: rtl/alsu_cmd_arbiter.sv
// alsu_cmd_arbiter: shares one ALSU between NUM_REQ requesters, one command outstanding at a time
// req_*: per-requester valid/ready command intake; rsp_*: shared tagged response channel
// alsu_*_o: registered ALSU operands/controls; alsu_out_i/alsu_leds_i: ALSU results captured ALSU_LAT cycles after issue
// Optional: ALSU_CMD_CHECK_EN rejects illegal commands with rsp_err_o instead of issuing them
module alsu_cmd_arbiter import alsu_ctrl_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int ALSU_LAT = 2,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*CMD_W-1:0] req_cmd_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [ID_W-1:0]          rsp_id_o,
  output logic signed [5:0]        rsp_out_o,
  output logic [15:0]              rsp_leds_o,
  output logic                     rsp_err_o,
  output logic [2:0]               alsu_opcode_o,
  output logic signed [2:0]        alsu_A_o,
  output logic signed [2:0]        alsu_B_o,
  output logic                     alsu_cin_o,
  output logic                     alsu_serial_in_o,
  output logic                     alsu_direction_o,
  output logic                     alsu_red_op_A_o,
  output logic                     alsu_red_op_B_o,
  output logic                     alsu_bypass_A_o,
  output logic                     alsu_bypass_B_o,
  input  logic signed [5:0]        alsu_out_i,
  input  logic [15:0]              alsu_leds_i
);
  localparam int CNT_W = $clog2(ALSU_LAT) + 1;
  arb_state_e state_q, state_d;
  alsu_cmd_t cmd_q, cmd_d, alsu_q, alsu_d;
  logic [ID_W-1:0] rr_q, rr_d, id_q, id_d, rsp_id_q, rsp_id_d, gnt_id;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt;
  logic any, illegal;
  logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic signed [5:0] rsp_out_q, rsp_out_d;
  logic [15:0] rsp_leds_q, rsp_leds_d;
  alsu_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req_i(req_valid_i), .ptr_i(rr_q), .gnt_o(gnt), .gnt_id_o(gnt_id), .any_o(any)
  );
`ifdef ALSU_CMD_CHECK_EN
  assign illegal = cmd_illegal(cmd_q);
`else
  assign illegal = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    cmd_d = cmd_q;
    id_d = id_q;
    alsu_d = alsu_q;
    cnt_d = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d = rsp_id_q;
    rsp_out_d = rsp_out_q;
    rsp_leds_d = rsp_leds_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      IDLE: if (any) begin
        cmd_d = alsu_cmd_t'(req_cmd_i[gnt_id*CMD_W +: CMD_W]);
        id_d = gnt_id;
        rr_d = (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
        state_d = ISSUE;
      end
      ISSUE: if (illegal) begin
        rsp_valid_d = 1'b1;
        rsp_err_d = 1'b1;
        rsp_out_d = '0;
        rsp_leds_d = '0;
        rsp_id_d = id_q;
        state_d = RESP;
      end else begin
        alsu_d = cmd_q;
        cnt_d = CNT_W'(ALSU_LAT - 1);
        state_d = WAIT;
      end
      WAIT: if (cnt_q == '0) begin
        rsp_valid_d = 1'b1;
        rsp_err_d = 1'b0;
        rsp_out_d = alsu_out_i;
        rsp_leds_d = alsu_leds_i;
        rsp_id_d = id_q;
        state_d = RESP;
      end else cnt_d = cnt_q - 1'b1;
      RESP: if (rsp_ready_i) begin
        rsp_valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rr_q <= '0;
      cmd_q <= '0;
      id_q <= '0;
      alsu_q <= '0;
      cnt_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q <= '0;
      rsp_out_q <= '0;
      rsp_leds_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      cmd_q <= cmd_d;
      id_q <= id_d;
      alsu_q <= alsu_d;
      cnt_q <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q <= rsp_id_d;
      rsp_out_q <= rsp_out_d;
      rsp_leds_q <= rsp_leds_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  // Ready is gated by reset so nothing looks accepted while the block is held in reset.
  assign req_ready_o = (state_q == IDLE && rst_ni) ? gnt : '0;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o = rsp_id_q;
  assign rsp_out_o = rsp_out_q;
  assign rsp_leds_o = rsp_leds_q;
  assign rsp_err_o = rsp_err_q;
  assign alsu_opcode_o = alsu_q.opcode;
  assign alsu_A_o = alsu_q.A;
  assign alsu_B_o = alsu_q.B;
  assign alsu_cin_o = alsu_q.cin;
  assign alsu_serial_in_o = alsu_q.serial_in;
  assign alsu_direction_o = alsu_q.direction;
  assign alsu_red_op_A_o = alsu_q.red_op_A;
  assign alsu_red_op_B_o = alsu_q.red_op_B;
  assign alsu_bypass_A_o = alsu_q.bypass_A;
  assign alsu_bypass_B_o = alsu_q.bypass_B;
endmodule

// File: tb/tb_alsu_cmd_arbiter.sv
// tb_alsu_cmd_arbiter: directed self-checking bench with a one-stage behavioural ALSU and cycle-stamped leds
module tb_alsu_cmd_arbiter;
  import alsu_ctrl_pkg::*;
  logic clk = 1'b0, rst_n;
  logic [3:0] req_valid, req_ready;
  logic [4*CMD_W-1:0] req_cmd;
  logic rsp_valid, rsp_ready, rsp_err;
  logic [1:0] rsp_id;
  logic signed [5:0] rsp_out, alsu_out;
  logic [15:0] rsp_leds, alsu_leds;
  logic [2:0] alsu_opcode;
  logic signed [2:0] alsu_A, alsu_B;
  logic alsu_cin, alsu_serial_in, alsu_direction, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B;
  logic [5:0] fake_q;
  logic bad;
  int cyc = 0, t0, checks = 0, errors = 0;
  always #5 clk = ~clk;
  alsu_cmd_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready), .req_cmd_i(req_cmd),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id), .rsp_out_o(rsp_out),
    .rsp_leds_o(rsp_leds), .rsp_err_o(rsp_err), .alsu_opcode_o(alsu_opcode), .alsu_A_o(alsu_A),
    .alsu_B_o(alsu_B), .alsu_cin_o(alsu_cin), .alsu_serial_in_o(alsu_serial_in),
    .alsu_direction_o(alsu_direction), .alsu_red_op_A_o(alsu_red_op_A), .alsu_red_op_B_o(alsu_red_op_B),
    .alsu_bypass_A_o(alsu_bypass_A), .alsu_bypass_B_o(alsu_bypass_B), .alsu_out_i(alsu_out),
    .alsu_leds_i(alsu_leds)
  );
  function automatic logic [5:0] alsu_f(input logic [2:0] op, input logic signed [2:0] a,
                                        input logic signed [2:0] b, input logic cin);
    logic signed [5:0] ea, eb;
    ea = a;
    eb = b;
    return (op == ADD) ? ea + eb + 6'(cin) : (op == MULT) ? ea * eb :
           (op == OR) ? (ea | eb) : (op == XOR) ? (ea ^ eb) : 6'd0;
  endfunction
  // Result appears one cycle after the ALSU samples its inputs; leds carry the current cycle number.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    fake_q <= alsu_f(alsu_opcode, alsu_A, alsu_B, alsu_cin);
  end
  assign alsu_out = fake_q;
  assign alsu_leds = cyc[15:0];
  function automatic alsu_cmd_t mk(input logic [2:0] op, input logic signed [2:0] a, input logic signed [2:0] b);
    mk = '0;
    mk.opcode = op;
    mk.A = a;
    mk.B = b;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ready();
    for (int n = 0; n < 20 && req_ready == 4'b0; n++) step();
    chk("ready_timeout", {31'b0, |req_ready}, 1);
  endtask
  task automatic wait_rsp();
    for (int n = 0; n < 20 && !rsp_valid; n++) step();
    chk("rsp_timeout", {31'b0, rsp_valid}, 1);
  endtask
  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_cmd = '0;
    rsp_ready = 1'b0;
    repeat (2) step();
    req_valid = 4'hF;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp", {rsp_valid, rsp_id, rsp_out, rsp_leds, rsp_err}, 0);
    chk("rst_alsu", {alsu_opcode, alsu_A, alsu_B, alsu_cin, alsu_serial_in, alsu_direction,
                     alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B}, 0);
    req_valid = '0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) req_cmd[i*CMD_W +: CMD_W] = mk(ADD, 3'(i), 3'sd1);
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    #1;
    for (int k = 0; k < 5; k++) begin
      wait_ready();
      chk("rr_grant", req_ready, 32'd1 << (k % 4));
      t0 = cyc;
      step();
      chk("rr_busy", req_ready, 0);
      wait_rsp();
      chk("rr_lat", cyc - t0, 4);
      chk("rr_id", rsp_id, k % 4);
      chk("rr_out", $unsigned(rsp_out), k % 4 + 1);
      chk("rr_leds", rsp_leds, 16'(t0 + 3));
      step();
    end
    req_valid = '0;
    req_cmd[0 +: CMD_W] = mk(ADD, 3'sd3, -3'sd2);
    rsp_ready = 1'b0;
    step();
    req_valid = 4'b0001;
    #1;
    chk("single_grant", req_ready, 1);
    t0 = cyc;
    step();
    req_valid = '0;
    step();
    step();
    chk("single_early", rsp_valid, 0);
    step();
    chk("single_valid", rsp_valid, 1);
    chk("single_lat", cyc - t0, 4);
    chk("single_id_out", {rsp_id, rsp_out}, {2'd0, 6'd1});
    step();
    chk("single_hold", {rsp_valid, rsp_out}, {1'b1, 6'd1});
    rsp_ready = 1'b1;
    step();
    chk("single_done", rsp_valid, 0);
    rsp_ready = 1'b0;
    req_cmd[1*CMD_W +: CMD_W] = mk(XOR, 3'sd3, 3'sd1);
    req_cmd[2*CMD_W +: CMD_W] = mk(OR, 3'sd1, 3'sd2);
    req_valid = 4'hF;
    #1;
    chk("bp_grant", req_ready, 4'b0010);
    t0 = cyc;
    step();
    wait_rsp();
    chk("bp_out", $unsigned(rsp_out), 2);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_data", {rsp_id, rsp_out, rsp_leds}, {2'd1, 6'd2, 16'(t0 + 3)});
      chk("bp_hold_ready", req_ready, 0);
      chk("bp_hold_alsu", alsu_opcode, XOR);
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_regrant", {rsp_valid, req_ready}, {1'b0, 4'b0100});
    step();
    req_valid = '0;
    wait_rsp();
    chk("bp2_id_out", {rsp_id, rsp_out}, {2'd2, 6'd3});
    step();
    req_cmd[1*CMD_W +: CMD_W] = mk(MULT, 3'sd2, 3'sd3);
    req_valid = 4'b0010;
    #1;
    chk("wrap_grant", req_ready, 4'b0010);
    step();
    req_valid = '0;
    wait_rsp();
    chk("wrap_id_out", {rsp_id, rsp_out}, {2'd1, 6'd6});
    step();
    req_cmd[3*CMD_W +: CMD_W] = mk(ADD, 3'sd1, 3'sd1);
    req_valid = 4'b1011;
    #1;
    chk("wrap_ptr", req_ready, 4'b1000);
    step();
    req_valid = '0;
    wait_rsp();
    chk("wrap3_id_out", {rsp_id, rsp_out}, {2'd3, 6'd2});
    step();
    req_cmd[0 +: CMD_W] = mk(ADD, 3'sd2, 3'sd2);
    req_valid = 4'b0001;
    #1;
    chk("mid_grant", req_ready, 1);
    step();
    req_valid = '0;
    step();
    chk("mid_issued", alsu_opcode, ADD);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_alsu", {alsu_opcode, alsu_A, alsu_B}, 0);
    chk("mid_rst_rsp", {rsp_valid, rsp_id, rsp_out, rsp_leds, rsp_err, req_ready}, 0);
    step();
    step();
    rst_n = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      bad = bad | rsp_valid;
    end
    chk("mid_no_rsp", bad, 0);
    req_cmd[0 +: CMD_W] = mk(ADD, 3'sd1, 3'sd0);
    req_cmd[3*CMD_W +: CMD_W] = mk(OR, 3'sd2, 3'sd1);
    req_valid = 4'b1001;
    #1;
    chk("post_rst_grant", req_ready, 4'b0001);
    step();
    req_valid = '0;
    wait_rsp();
    chk("post_rst_id_out", {rsp_id, rsp_out}, {2'd0, 6'd1});
    step();
    req_cmd[1*CMD_W +: CMD_W] = mk(3'd7, 3'sd1, 3'sd1);
    req_valid = 4'b0010;
    #1;
    chk("op7_grant", req_ready, 4'b0010);
    t0 = cyc;
    step();
    req_valid = '0;
`ifdef ALSU_CMD_CHECK_EN
    step();
    chk("op7_err_resp", {rsp_valid, rsp_err, rsp_id, rsp_out, rsp_leds}, {1'b1, 1'b1, 2'd1, 6'd0, 16'd0});
    chk("op7_lat", cyc - t0, 2);
    chk("op7_alsu_kept", alsu_opcode, ADD);
`else
    wait_rsp();
    chk("op7_lat", cyc - t0, 4);
    chk("op7_issued", {rsp_err, rsp_id, rsp_out, alsu_opcode}, {1'b0, 2'd1, 6'd0, 3'd7});
    chk("op7_leds", rsp_leds, 16'(t0 + 3));
`endif
    step();
    chk("op7_done", rsp_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
